mem_dat_bytes: RTL and testbench
================================

Name: mem_dat_bytes

Overview:
Parametrised byte-addressed data memory for the RISC-V core running merge sort.
- Supports RV32 load/store sizes: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Uses a registered, one-cycle read with a valid strobe.
- Detects misaligned accesses.
- Performs an optional post-reset clear sweep.
- Sits between the execute/mem stage and the load writeback mux.

Parameters:
DEPTH, 256, number of 32-bit words; must be a power of two, ≥4.
ADDR_W, 32, width of the byte address from the ALU.
IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present this cycle.
req_ready  output  1  block can accept a request.
esc_mem  input  1  store request.
read_mem  input  1  load request.
addr  input  ADDR_W  byte address.
size  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
wdata  input  32  store data, taken from the low bits.
rdata  output  32  load result, extended per size.
rvalid  output  1  one-cycle pulse; rdata is valid.
misalign  output  1  one-cycle pulse; the last accepted request was misaligned or used an illegal size.
init_done  output  1  memory ready for traffic.

Behaviour:
- Reset values: req_ready=0, rvalid=0, rdata=0, misalign=0, init_done=0, state=INIT, sweep index=0.
- Accept condition: req_valid & req_ready & (esc_mem | read_mem).
- Addressing:
  - Word index = addr[IDX_W+1:2]; upper bits are ignored, so addresses wrap modulo DEPTH*4.
  - Lane = addr[1:0].
- Alignment rules:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=00.
  - A violation or illegal size means: no write, misalign=1 next cycle, and, if read_mem, rvalid=1 with rdata=0.
- Store, on accepted esc_mem:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
  - The write commits at the rising edge of the accept cycle.
- Load, on accepted read_mem:
  - The word is read at the accept edge.
  - rdata and rvalid=1 appear in the following cycle, i.e. 1-cycle latency.
  - B/H are sign-extended; BU/HU are zero-extended; W is returned as is.
  - rdata holds its value after rvalid drops until the next load completes.
- esc_mem and read_mem together:
  - Both are performed.
  - The read returns the pre-write contents (read-before-write).
- Back-to-back requests are accepted every cycle; throughput is 1 per cycle.
- Store followed by a load of the same word in the next cycle returns the new data.
- State machine:
  - INIT: req_ready=0. Word[sweep] is set to 0 and sweep increments. When sweep reaches DEPTH-1, go to RUN next cycle. Duration is DEPTH cycles.
  - RUN: req_ready=1, init_done=1. Stays in RUN until reset.
- Reset asserted mid-INIT or mid-RUN:
  - Outputs return to reset values immediately.
  - An in-flight load is dropped; no rvalid.
  - The sweep restarts from index 0.
- Requests presented while req_ready=0 are ignored, with no side effects.

Optional Feature:
MEMDAT_INIT_CLEAR_EN
- Defined: INIT sweep as described above; all words read 0 after init_done.
- Undefined:
  - No INIT state; the FSM enters RUN on the first clock after reset deasserts.
  - init_done=1 and req_ready=1 from that edge.
  - Memory contents are whatever the initial block or $readmemh loaded; they are not cleared by reset.

Test Plan:
1. Reset, then wait, with the macro defined and DEPTH=256 → init_done rises exactly 256 cycles after reset falls; LW at 0x3FC returns 0x00000000.
2. SW 0xDEADBEEF @0x10, then LB @0x13, LBU @0x13, LH @0x12, LHU @0x12, LW @0x10 → 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF, each with rvalid one cycle after accept.
3. SW 0x11223344 @0x20, SB 0xAA @0x21, SH 0x5566 @0x22 → LW @0x20 returns 0x5566AA44.
4. LW @0x22 and SH @0x41 → misalign pulses; memory is unchanged; the LW returns rvalid with rdata=0.
5. esc_mem+read_mem together, SW 0x1 @0x30 over old value 0x7 → rdata=0x7; a next-cycle LW @0x30 returns 0x1. Address 0x430 aliases 0x30 when DEPTH=256.
6. Assert reset one cycle after an LW accept and during INIT sweep index 100 → no rvalid; init_done=0; the sweep restarts and completes 256 cycles after release.

Source files
------------

// File: rtl/mem_dat_bytes.sv
// Byte-addressed RV32 data memory: sized loads/stores, one-cycle registered read, misalign detect.
// Build option MEMDAT_INIT_CLEAR_EN enables the post-reset zeroing sweep before init_done.
module mem_dat_bytes #(
  parameter  int DEPTH  = 256,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              esc_mem,
  input  logic              read_mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              misalign,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t state, state_next;

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx_p0;
  logic [1:0]       lane_p0;
  logic             accept_p0;
  logic             bad_p0;
  logic             wr_p0;
  logic [3:0]       be_p0;
  logic [31:0]      wlanes_p0;
  logic             clr;
  logic [IDX_W-1:0] sweep;

  logic [31:0]      rdata_p1;
  logic             vld_p1;
  logic             mis_p1;

  wire unused_addr = &{1'b0, addr[ADDR_W-1:IDX_W+2]};

  function automatic logic bad_access(input logic [2:0] sz, input logic [1:0] ln);
    case (sz)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return ln[0];
      3'b010:         return ln != 2'b00;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] sz, input logic [1:0] ln);
    case (sz[1:0])
      2'b00:   return 4'b0001 << ln;
      2'b01:   return 4'b0011 << {ln[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] sz, input logic [31:0] d);
    case (sz[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] sz,
                                           input logic [1:0] ln);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = word >> {ln, 3'b000};
    hsh = word >> {ln[1], 4'b0000};
    case (sz)
      3'b000:  return {{24{bsh[7]}}, bsh[7:0]};
      3'b100:  return {24'd0, bsh[7:0]};
      3'b001:  return {{16{hsh[15]}}, hsh[15:0]};
      3'b101:  return {16'd0, hsh[15:0]};
      default: return word;
    endcase
  endfunction

  // Stage p0: request decode in the accept cycle
  assign idx_p0    = addr[IDX_W+1:2];
  assign lane_p0   = addr[1:0];
  assign accept_p0 = req_valid & req_ready & (esc_mem | read_mem);
  assign bad_p0    = bad_access(size, lane_p0);
  assign wr_p0     = accept_p0 & esc_mem & ~bad_p0;
  assign be_p0     = byte_en(size, lane_p0);
  assign wlanes_p0 = store_lanes(size, wdata);

`ifdef MEMDAT_INIT_CLEAR_EN
  assign clr = (state == INIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sweep <= '0;
    end else if (state == INIT) begin
      sweep <= sweep + 1'b1;
    end
  end
`else
  assign clr   = 1'b0;
  assign sweep = '0;
`endif

  always_ff @(posedge clock) begin
    if (clr) begin
      mem[sweep] <= '0;
    end else if (wr_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p0[i]) mem[idx_p0][8*i +: 8] <= wlanes_p0[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
`ifdef MEMDAT_INIT_CLEAR_EN
      INIT: if (sweep == IDX_W'(DEPTH - 1)) state_next = RUN;
`else
      INIT: state_next = RUN;
`endif
      RUN:  state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    if (state == RUN) begin
      req_ready = 1'b1;
      init_done = 1'b1;
    end
  end

  // Stage p1: read word captured at the accept edge (pre-write contents), extended by size
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0 & read_mem;
      mis_p1 <= accept_p0 & bad_p0;
      if (accept_p0 & read_mem) begin
        rdata_p1 <= bad_p0 ? 32'd0 : load_ext(mem[idx_p0], size, lane_p0);
      end
    end
  end

  assign rdata    = rdata_p1;
  assign rvalid   = vld_p1;
  assign misalign = mis_p1;

endmodule

// File: tb/tb_mem_dat_bytes.sv
// Scoreboard bench for mem_dat_bytes: expectations queued at accept, checked on the following cycle.
module tb_mem_dat_bytes;

  localparam int DEPTH = 256;
`ifdef MEMDAT_INIT_CLEAR_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        esc_mem = 1'b0;
  logic        read_mem = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  size = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;
  logic        init_done;

  typedef struct packed {
    logic        mis;
    logic        rv;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;

  mem_dat_bytes #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .esc_mem(esc_mem), .read_mem(read_mem), .addr(addr), .size(size), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .misalign(misalign), .init_done(init_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
      chk("rvalid", {31'd0, rvalid}, {31'd0, e.rv});
      if (e.rv) chk("rdata", rdata, e.data);
    end else if (rvalid || misalign) begin
      chk("spurious", {30'd0, rvalid, misalign}, 32'd0);
    end
  end

  task automatic issue(input logic es, input logic rd, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd,
                       input logic mis, input logic [31:0] exp_d);
    exp_t e;
    req_valid = 1'b1; esc_mem = es; read_mem = rd; addr = a; size = sz; wdata = wd;
    @(posedge clock);
    e.mis = mis; e.rv = rd; e.data = exp_d;
    expq.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; esc_mem = 1'b0; read_mem = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 3 * DEPTH) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(tag, n, INIT_CYC);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_initdone", {31'd0, init_done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {30'd0, rvalid, misalign}, 32'd0);
    reset = 1'b0;
    wait_init("init_cycles");
    chk("run_ready", {31'd0, req_ready}, 32'd1);

`ifdef MEMDAT_INIT_CLEAR_EN
    issue(0, 1, 32'h3FC, 3'b010, 0, 0, 32'h0000_0000);
`endif

    // Sized loads from one stored word, back to back
    issue(1, 0, 32'h10, 3'b010, 32'hDEAD_BEEF, 0, 0);
    issue(0, 1, 32'h13, 3'b000, 0, 0, 32'hFFFF_FFDE);
    issue(0, 1, 32'h13, 3'b100, 0, 0, 32'h0000_00DE);
    issue(0, 1, 32'h12, 3'b001, 0, 0, 32'hFFFF_DEAD);
    issue(0, 1, 32'h12, 3'b101, 0, 0, 32'h0000_DEAD);
    issue(0, 1, 32'h10, 3'b010, 0, 0, 32'hDEAD_BEEF);
    issue(0, 1, 32'h11, 3'b100, 0, 0, 32'h0000_00BE);
    issue(0, 1, 32'h10, 3'b001, 0, 0, 32'hFFFF_BEEF);

    // Partial stores merge into a word
    issue(1, 0, 32'h20, 3'b010, 32'h1122_3344, 0, 0);
    issue(1, 0, 32'h21, 3'b000, 32'hFFFF_FFAA, 0, 0);
    issue(1, 0, 32'h22, 3'b001, 32'h1234_5566, 0, 0);
    issue(0, 1, 32'h20, 3'b010, 0, 0, 32'h5566_AA44);

    // Misaligned and illegal-size accesses
    issue(1, 0, 32'h40, 3'b010, 32'hCAFE_F00D, 0, 0);
    issue(0, 1, 32'h22, 3'b010, 0, 1, 32'h0);
    issue(1, 0, 32'h41, 3'b001, 32'h0000_9999, 1, 0);
    issue(1, 0, 32'h40, 3'b011, 32'h7777_7777, 1, 0);
    issue(0, 1, 32'h40, 3'b110, 0, 1, 32'h0);
    issue(0, 1, 32'h43, 3'b101, 0, 1, 32'h0);
    issue(0, 1, 32'h40, 3'b010, 0, 0, 32'hCAFE_F00D);
    issue(0, 1, 32'h20, 3'b010, 0, 0, 32'h5566_AA44);

    // Read-before-write on combined request, then address aliasing
    issue(1, 0, 32'h30, 3'b010, 32'h0000_0007, 0, 0);
    issue(1, 1, 32'h30, 3'b010, 32'h0000_0001, 0, 32'h0000_0007);
    issue(0, 1, 32'h30, 3'b010, 0, 0, 32'h0000_0001);
    issue(0, 1, 32'h430, 3'b010, 0, 0, 32'h0000_0001);
    issue(1, 0, 32'h834, 3'b010, 32'h5A5A_0F0F, 0, 0);
    issue(0, 1, 32'h34, 3'b010, 0, 0, 32'h5A5A_0F0F);
    issue(1, 0, 32'h50, 3'b010, 32'h0BAD_F00D, 0, 0);
    idle(3);
    chk("rdata_hold", rdata, 32'h5A5A_0F0F);

    // Reset right after a load accept drops the response
    begin
      exp_t e;
      req_valid = 1'b1; esc_mem = 1'b0; read_mem = 1'b1; addr = 32'h10; size = 3'b010;
      @(posedge clock);
      #1;
      reset = 1'b1;
      req_valid = 1'b0; read_mem = 1'b0;
      e.mis = 1'b0; e.rv = 1'b0; e.data = '0;
      expq.push_back(e);
    end
    #1;
    chk("midrst_initdone", {31'd0, init_done}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    // Requests while not ready are ignored
    req_valid = 1'b1; esc_mem = 1'b1; addr = 32'h50; size = 3'b010; wdata = 32'h1111_2222;
    repeat (2) @(posedge clock);
    #1;
    req_valid = 1'b0; esc_mem = 1'b0;
    reset = 1'b0;
`ifdef MEMDAT_INIT_CLEAR_EN
    repeat (100) @(posedge clock);
    #1;
    chk("sweep_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("sweep_rst_initdone", {31'd0, init_done}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
`endif
    wait_init("reinit_cycles");

`ifdef MEMDAT_INIT_CLEAR_EN
    issue(0, 1, 32'h10, 3'b010, 0, 0, 32'h0000_0000);
    issue(0, 1, 32'h50, 3'b010, 0, 0, 32'h0000_0000);
`else
    issue(0, 1, 32'h10, 3'b010, 0, 0, 32'hDEAD_BEEF);
    issue(0, 1, 32'h50, 3'b010, 0, 0, 32'h0BAD_F00D);
`endif
    idle(3);
    chk("drain", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
